// File: rtl/pdm_rgb_demod_pkg.sv
// ------------------------------------------------------------------
// pdm_pkg : shared constants, types and saturate/truncate helper
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

  localparam int NUM_CH = 3;
  localparam int OUT_W  = 8;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef logic [OUT_W-1:0] pix_t;

  // Clamp a window total to 2^wlog2-1, then keep the top OUT_W bits.
  function automatic pix_t sat_trunc(input logic [31:0] tot, input int wlog2);
    logic [31:0] lim;
    logic [31:0] sat;
    lim = (32'd1 << wlog2) - 32'd1;
    sat = (tot > lim) ? lim : tot;
    sat = sat >> (wlog2 - OUT_W);
    return sat[OUT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_rgb_demod_if.sv
// ------------------------------------------------------------------
// pdm_rgb_demod_if : RGB result word with valid/ready handshake
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pdm_rgb_demod_if;
  import pdm_pkg::*;

  logic [OUT_W-1:0] led_r_out;
  logic [OUT_W-1:0] led_g_out;
  logic [OUT_W-1:0] led_b_out;
  logic             valid;
  logic             ready;

  modport master (
    output led_r_out, led_g_out, led_b_out, valid,
    input  ready
  );

  modport slave (
    input  led_r_out, led_g_out, led_b_out, valid,
    output ready
  );

endinterface

`default_nettype wire

// File: rtl/pdm_rgb_demod_chan_acc.sv
// ------------------------------------------------------------------
// pdm_chan_acc : one channel - synchroniser, ones counter, saturation
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pdm_chan_acc
  import pdm_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             pdm_i,
  input  wire logic             clear_i,
  input  wire logic             step_i,
  input  wire logic             close_i,
  output      logic [OUT_W-1:0] result_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [WINDOW_LOG2:0]   acc_q;
  logic [WINDOW_LOG2:0]   acc_d;
  logic [WINDOW_LOG2:0]   tot;
  logic                   samp;

  assign samp     = sync_q[SYNC_STAGES-1];
  // Total includes the sample arriving on the closing edge itself.
  assign tot      = acc_q + {{WINDOW_LOG2{1'b0}}, samp};
  assign result_o = sat_trunc(32'(tot), WINDOW_LOG2);

  always_comb begin
    acc_d = acc_q;
    if (clear_i || close_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = tot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      acc_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_i};
      acc_q  <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pdm_rgb_demod.sv
// ------------------------------------------------------------------
// pdm_rgb_demod : three-channel PDM demodulator with valid/ready output
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pdm_rgb_demod
  import pdm_pkg::*;
#(
  parameter int WINDOW_LOG2 = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              enable,
  input  wire logic [NUM_CH-1:0] pdm_in,
  pdm_rgb_demod_if.master        out_if,
  output      logic              overrun,
  input  wire logic              overrun_clr
);

  localparam logic [WINDOW_LOG2-1:0] WCNT_MAX = '1;

  logic [WINDOW_LOG2-1:0]         wcnt_q;
  logic [WINDOW_LOG2-1:0]         wcnt_d;
  logic [NUM_CH-1:0][OUT_W-1:0]   chan_res;
  logic [NUM_CH-1:0][OUT_W-1:0]   word_q;
  logic [NUM_CH-1:0][OUT_W-1:0]   word_d;
  logic                           valid_q;
  logic                           valid_d;
  logic                           ovr_q;
  logic                           ovr_d;
  logic                           close;
  logic                           accept;

  assign close  = enable && (wcnt_q == WCNT_MAX);
  assign accept = valid_q && out_if.ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pdm_chan_acc #(
      .WINDOW_LOG2 (WINDOW_LOG2),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .pdm_i    (pdm_in[i]),
      .clear_i  (!enable),
      .step_i   (enable),
      .close_i  (close),
      .result_o (chan_res[i])
    );
  end

  always_comb begin
    wcnt_d  = enable ? (wcnt_q + WINDOW_LOG2'(1)) : '0;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    // A close always loads; it only counts as overrun if the old word was not taken.
    if (close) begin
      word_d  = chan_res;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (close && valid_q && !out_if.ready) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.led_r_out = word_q[CH_R];
  assign out_if.led_g_out = word_q[CH_G];
  assign out_if.led_b_out = word_q[CH_B];
  assign out_if.valid     = valid_q;
  assign overrun          = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_rgb_demod.sv
// ------------------------------------------------------------------
// tb_pdm_rgb_demod : self-checking bench with window-count reference model
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pdm_rgb_demod;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int NW   = 1 << W;
  localparam int W2   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, overrun, overrun_clr;
  logic [2:0] pdm_in;
  logic       rst2, enable2, overrun2, clr2;
  logic [2:0] pdm2;
  logic       done2;

  pdm_rgb_demod_if if0 ();
  pdm_rgb_demod_if if1 ();

  pdm_rgb_demod #(.WINDOW_LOG2(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pdm_in(pdm_in),
    .out_if(if0), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  pdm_rgb_demod #(.WINDOW_LOG2(W2), .SYNC_STAGES(SYNC)) dut10 (
    .clk(clk), .rst(rst2), .enable(enable2), .pdm_in(pdm2),
    .out_if(if1), .overrun(overrun2), .overrun_clr(clr2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: samples queue through a SYNC-deep delay, windows are
  // collected whole and their ones counted when the window is full.
  logic [2:0] hist[$];
  logic [2:0] win[$];
  logic [7:0] m_out[3];
  logic       m_valid, m_ovr;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back(3'b000);
    win.delete();
    for (int ch = 0; ch < 3; ch++) m_out[ch] = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    logic       cl;
    int         cnt;
    logic [7:0] word[3];
    hist.push_back(pdm_in);
    s  = hist.pop_front();
    cl = 1'b0;
    for (int ch = 0; ch < 3; ch++) word[ch] = 8'h00;
    if (enable) begin
      win.push_back(s);
      if (win.size() == NW) begin
        cl = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
          cnt = 0;
          foreach (win[k]) cnt += int'(win[k][ch]);
          if (cnt > NW - 1) cnt = NW - 1;
          word[ch] = 8'(cnt >> (W - 8));
        end
        win.delete();
      end
    end else begin
      win.delete();
    end
    if (cl) begin
      if (m_valid && !if0.ready) m_ovr = 1'b1;
      else if (overrun_clr)      m_ovr = 1'b0;
      for (int ch = 0; ch < 3; ch++) m_out[ch] = word[ch];
      m_valid = 1'b1;
    end else begin
      if (m_valid && if0.ready) m_valid = 1'b0;
      if (overrun_clr)          m_ovr = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    chk("led_r",   if0.led_r_out, m_out[0]);
    chk("led_g",   if0.led_g_out, m_out[1]);
    chk("led_b",   if0.led_b_out, m_out[2]);
    chk("valid",   if0.valid,     m_valid);
    chk("overrun", overrun,       m_ovr);
  endtask

  task automatic to_close();
    int n = 0;
    while (win.size() != NW - 1 && n < 400) begin
      pdm_in = 3'($urandom);
      tick();
      n++;
    end
    if (win.size() != NW - 1) chk("to_close_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] mc[3];
  logic [7:0] ma[3];

  task automatic mod_step();
    logic [8:0] t9;
    for (int ch = 0; ch < 3; ch++) begin
      t9         = {1'b0, ma[ch]} + {1'b0, mc[ch]};
      pdm_in[ch] = t9[8];
      ma[ch]     = t9[7:0];
    end
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 0;
    while (!if0.valid && n < 300) begin
      tick();
      n++;
    end
    if (!if0.valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [2:0] pdm;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    int words;

    tbl[0] = '{3'b111, 8'hFF, 8'hFF, 8'hFF};
    tbl[1] = '{3'b000, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{3'b001, 8'hFF, 8'h00, 8'h00};
    tbl[3] = '{3'b010, 8'h00, 8'hFF, 8'h00};
    tbl[4] = '{3'b100, 8'h00, 8'h00, 8'hFF};
    tbl[5] = '{3'b101, 8'hFF, 8'h00, 8'hFF};

    rst = 1'b0; enable = 1'b0; pdm_in = 3'b000; overrun_clr = 1'b0; if0.ready = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_led_r", if0.led_r_out, 32'h00);
    chk("rst_valid", if0.valid, 32'd0);
    chk("rst_ovr",   overrun, 32'd0);
    rst = 1'b1;

    // Constant-input windows from the table
    for (int t = 0; t < 6; t++) begin
      enable = 1'b0; pdm_in = tbl[t].pdm; if0.ready = 1'b1;
      repeat (4) tick();
      enable = 1'b1;
      wait_valid("tbl", n);
      chk("tbl_latency", n, 32'd256);
      chk("tbl_r", if0.led_r_out, tbl[t].r);
      chk("tbl_g", if0.led_g_out, tbl[t].g);
      chk("tbl_b", if0.led_b_out, tbl[t].b);
    end

    // Loopback from a first-order modulator
    enable = 1'b0; tick();
    mc[0] = 8'h00; mc[1] = 8'h80; mc[2] = 8'hFF;
    for (int ch = 0; ch < 3; ch++) ma[ch] = 8'h00;
    enable = 1'b1; if0.ready = 1'b1; words = 0;
    for (int k = 0; k < 1200; k++) begin
      mod_step();
      tick();
      if (if0.valid) begin
        words++;
        if (words > 1) begin
          chk("lb_r", if0.led_r_out, 32'h00);
          chk("lb_g", if0.led_g_out, 32'h80);
          chk("lb_b", if0.led_b_out, 32'hFF);
        end
      end
    end
    chk("lb_words", 32'(words >= 4), 32'd1);

    // Overrun, set-beats-clear, and accept on the close edge
    enable = 1'b0; overrun_clr = 1'b1; tick(); tick();
    overrun_clr = 1'b0; if0.ready = 1'b0; enable = 1'b1;
    to_close(); tick();
    chk("ov1_valid", if0.valid, 32'd1);
    chk("ov1_flag",  overrun,   32'd0);
    to_close(); tick();
    chk("ov2_valid", if0.valid, 32'd1);
    chk("ov2_flag",  overrun,   32'd1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ov_clr", overrun, 32'd0);
    to_close(); overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ov3_set_wins", overrun, 32'd1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ov_clr2", overrun, 32'd0);
    to_close(); if0.ready = 1'b1; tick();
    chk("acc_close_valid", if0.valid, 32'd1);
    chk("acc_close_ovr",   overrun,   32'd0);
    tick();
    chk("acc_drain", if0.valid, 32'd0);

    // Enable dropped mid-window, then re-enabled
    enable = 1'b0; tick();
    enable = 1'b1; pdm_in = 3'b111;
    repeat (100) tick();
    enable = 1'b0;
    repeat (50) tick();
    chk("drop_no_word", if0.valid, 32'd0);
    enable = 1'b1;
    wait_valid("reen", n);
    chk("reen_latency", n, 32'd256);
    chk("reen_r", if0.led_r_out, 32'hFF);
    chk("reen_b", if0.led_b_out, 32'hFF);

    // Asynchronous reset mid-window with a word pending
    if0.ready = 1'b0;
    repeat (80) tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_led_r", if0.led_r_out, 32'h00);
    chk("arst_led_g", if0.led_g_out, 32'h00);
    chk("arst_valid", if0.valid,     32'd0);
    chk("arst_ovr",   overrun,       32'd0);
    model_reset();
    pdm_in = 3'b011; if0.ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    wait_valid("post_rst", n);
    chk("post_rst_latency", n, 32'd256);
    chk("post_rst_r", if0.led_r_out, 32'hFE);
    chk("post_rst_g", if0.led_g_out, 32'hFE);
    chk("post_rst_b", if0.led_b_out, 32'h00);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      pdm_in      = 3'($urandom);
      enable      = ((k % 900) < 880);
      if0.ready   = ($urandom_range(0, 3) == 0);
      overrun_clr = ($urandom_range(0, 99) < 5);
      tick();
    end
    overrun_clr = 1'b0;

    n = 0;
    while (!done2 && n < 20000) begin
      tick();
      n++;
    end
    chk("dut10_done", done2, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // WINDOW_LOG2 = 10 loopback with 0x37 on every channel
  initial begin
    logic [7:0] acc2;
    logic [8:0] t9;
    int         words2;
    int         last;
    rst2 = 1'b0; enable2 = 1'b0; pdm2 = 3'b000; clr2 = 1'b0; if1.ready = 1'b1; done2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b1; enable2 = 1'b1;
    acc2 = 8'h00; words2 = 0; last = 0;
    for (int c = 0; c < 5200; c++) begin
      t9   = {1'b0, acc2} + 9'h037;
      pdm2 = {3{t9[8]}};
      acc2 = t9[7:0];
      @(posedge clk);
      #1;
      if (if1.valid) begin
        words2++;
        if (words2 > 1) begin
          chk("w10_r", if1.led_r_out, 32'h37);
          chk("w10_g", if1.led_g_out, 32'h37);
          chk("w10_b", if1.led_b_out, 32'h37);
          chk("w10_period", c - last, 32'd1024);
        end
        last = c;
      end
    end
    chk("w10_words", 32'(words2 >= 4), 32'd1);
    done2 = 1'b1;
  end

endmodule

`default_nettype wire
